// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code receiver:
//   - ps2_state_t : receive FSM states
//   - SC_*        : scan codes the piano-tiles key checker cares about
//   - odd_parity_ok() : PS/2 frames carry odd parity over data + parity bit
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_F     = 8'h2B;
   localparam logic [7:0] SC_EMPTY = 8'h05;

   // True when the nine bits {data, parity} hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// -----------------------------------------------------------------------------
// ps2_input_filter
// Front end for the PS/2 pins: synchronises both pins into the CLOCK_50
// domain, removes short glitches from the PS/2 clock and produces a
// registered one-cycle strobe on each filtered falling edge.
// Ports:
//   CLOCK_50 in  system clock
//   reset    in  asynchronous, active-high
//   ps2_clk  in  raw PS/2 clock pin
//   ps2_dat  in  raw PS/2 data pin
//   fe       out 1-cycle strobe, filtered PS/2 clock went 1->0
//   dat_s    out synchronised PS/2 data
// Pin-to-fe latency is SYNC_STAGES + FILTER_CYCLES + 1 cycles.
// -----------------------------------------------------------------------------
module ps2_input_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 8
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fe,
   output logic dat_s
);

   localparam int            FW        = $clog2(FILTER_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] dat_sync_r;
   logic                   clk_smp_s;
   logic                   filt_clk_r;
   logic                   filt_clk_n_s;
   logic                   filt_prev_r;
   logic [FW-1:0]          filt_cnt_r;
   logic [FW-1:0]          filt_cnt_n_s;
   logic                   fe_r;

   assign clk_smp_s = clk_sync_r[SYNC_STAGES-1];

   // Synchroniser chains; idle bus level is high on both pins.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clk_sync_r <= {SYNC_STAGES{1'b1}};
         dat_sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_dat};
      end
   end

   // Glitch filter: the filtered clock follows only after FILTER_CYCLES
   // consecutive samples disagree with it; any agreeing sample restarts the run.
   always_comb begin
      filt_clk_n_s = filt_clk_r;
      filt_cnt_n_s = filt_cnt_r;
      if (clk_smp_s != filt_clk_r) begin
         if (filt_cnt_r >= FILT_LAST) begin
            filt_clk_n_s = clk_smp_s;
            filt_cnt_n_s = {FW{1'b0}};
         end else begin
            filt_cnt_n_s = filt_cnt_r + FW'(1);
         end
      end else begin
         filt_cnt_n_s = {FW{1'b0}};
      end
   end

   // Filter state and registered falling-edge detect.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         filt_clk_r  <= 1'b1;
         filt_prev_r <= 1'b1;
         filt_cnt_r  <= {FW{1'b0}};
         fe_r        <= 1'b0;
      end else begin
         filt_clk_r  <= filt_clk_n_s;
         filt_prev_r <= filt_clk_r;
         filt_cnt_r  <= filt_cnt_n_s;
         fe_r        <= filt_prev_r & ~filt_clk_r;
      end
   end

   assign fe    = fe_r;
   assign dat_s = dat_sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scan_receiver.sv
// -----------------------------------------------------------------------------
// ps2_scan_receiver
// Deserialises PS/2 keyboard frames (start, 8 data LSB-first, odd parity,
// stop) and forwards each good scan code to the piano-tiles key checker.
// Ports:
//   CLOCK_50         in  system clock, 50 MHz
//   reset            in  asynchronous, active-high
//   PS2_CLK          in  raw PS/2 clock pin
//   PS2_DAT          in  raw PS/2 data pin
//   received_data    out last good scan code, held until the next good frame
//   received_data_en out 1-cycle strobe, received_data updated
//   parity_error     out 1-cycle strobe, frame dropped on bad parity
//   frame_error      out 1-cycle strobe, frame dropped on bad stop or timeout
// The FSM only moves on a filtered falling edge, except when a partial frame
// has been idle for TIMEOUT_CYCLES, in which case it is abandoned.
// -----------------------------------------------------------------------------
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 10_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       parity_error,
   output logic       frame_error
);

   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          fe_s;
   logic          dat_s;

   ps2_state_t    state_r,   state_n_s;
   logic [2:0]    bit_cnt_r, bit_cnt_n_s;
   logic [7:0]    shift_r,   shift_n_s;
   logic          parity_r,  parity_n_s;
   logic [TW-1:0] to_cnt_r,  to_cnt_n_s;
   logic [7:0]    rx_data_r, rx_data_n_s;
   logic          rx_en_r,   rx_en_n_s;
   logic          perr_r,    perr_n_s;
   logic          ferr_r,    ferr_n_s;

   ps2_input_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .ps2_clk  (PS2_CLK),
      .ps2_dat  (PS2_DAT),
      .fe       (fe_s),
      .dat_s    (dat_s)
   );

   // Next-state and outcome logic. A falling edge always takes priority over
   // the timeout so a bit arriving on the last allowed cycle still counts.
   always_comb begin
      state_n_s   = state_r;
      bit_cnt_n_s = bit_cnt_r;
      shift_n_s   = shift_r;
      parity_n_s  = parity_r;
      to_cnt_n_s  = to_cnt_r;
      rx_data_n_s = rx_data_r;
      rx_en_n_s   = 1'b0;
      perr_n_s    = 1'b0;
      ferr_n_s    = 1'b0;

      if (fe_s) begin
         to_cnt_n_s = {TW{1'b0}};
         case (state_r)
            IDLE: begin
               // A high data line at a falling edge is not a start bit; ignore it.
               if (!dat_s) begin
                  state_n_s   = DATA;
                  bit_cnt_n_s = 3'd0;
                  shift_n_s   = 8'h00;
               end else begin
                  state_n_s   = IDLE;
               end
            end
            DATA: begin
               shift_n_s = {dat_s, shift_r[7:1]};
               if (bit_cnt_r == 3'd7) begin
                  state_n_s   = PARITY;
                  bit_cnt_n_s = 3'd0;
               end else begin
                  bit_cnt_n_s = bit_cnt_r + 3'd1;
               end
            end
            PARITY: begin
               parity_n_s = dat_s;
               state_n_s  = STOP;
            end
            STOP: begin
               state_n_s = IDLE;
               if (!dat_s) begin
                  ferr_n_s = 1'b1;
               end else if (!odd_parity_ok(shift_r, parity_r)) begin
                  perr_n_s = 1'b1;
               end else begin
                  rx_data_n_s = shift_r;
                  rx_en_n_s   = 1'b1;
               end
            end
            default: begin
               state_n_s = IDLE;
            end
         endcase
      end else if (state_r != IDLE) begin
         if (to_cnt_r >= TO_LAST) begin
            state_n_s   = IDLE;
            to_cnt_n_s  = {TW{1'b0}};
            bit_cnt_n_s = 3'd0;
            shift_n_s   = 8'h00;
            parity_n_s  = 1'b0;
            ferr_n_s    = 1'b1;
         end else begin
            to_cnt_n_s  = to_cnt_r + TW'(1);
         end
      end else begin
         to_cnt_n_s = {TW{1'b0}};
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         parity_r  <= 1'b0;
         to_cnt_r  <= {TW{1'b0}};
         rx_data_r <= 8'h00;
         rx_en_r   <= 1'b0;
         perr_r    <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         state_r   <= state_n_s;
         bit_cnt_r <= bit_cnt_n_s;
         shift_r   <= shift_n_s;
         parity_r  <= parity_n_s;
         to_cnt_r  <= to_cnt_n_s;
         rx_data_r <= rx_data_n_s;
         rx_en_r   <= rx_en_n_s;
         perr_r    <= perr_n_s;
         ferr_r    <= ferr_n_s;
      end
   end

   assign received_data    = rx_data_r;
   assign received_data_en = rx_en_r;
   assign parity_error     = perr_r;
   assign frame_error      = ferr_r;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_scan_receiver
// Drives PS/2 frames onto the pins and compares every outcome strobe against
// a frame-level model: each complete frame yields exactly one event whose
// kind follows from its stop bit and the odd parity of its nine payload bits.
// -----------------------------------------------------------------------------
module tb_ps2_scan_receiver;
   import ps2_pkg::*;

   localparam int EV_GOOD  = 1;
   localparam int EV_PERR  = 2;
   localparam int EV_FERR  = 3;
   localparam int EV_MULTI = 7;
   localparam int STROBE_LATENCY = 2 + 8 + 1 + 1;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         stamp;
   } ev_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       parity_error;
   logic       frame_error;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         last_fe_cyc = 0;
   logic [7:0] last_good = 8'h00;
   ev_t        obs_q[$];
   ev_t        exp_q[$];

   ps2_scan_receiver dut (
      .CLOCK_50         (CLOCK_50),
      .reset            (reset),
      .PS2_CLK          (PS2_CLK),
      .PS2_DAT          (PS2_DAT),
      .received_data    (received_data),
      .received_data_en (received_data_en),
      .parity_error     (parity_error),
      .frame_error      (frame_error)
   );

   always #1 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Record every strobe seen, sampled on the falling system-clock edge.
   always @(negedge CLOCK_50) begin
      int  n;
      ev_t e;
      n = int'(received_data_en) + int'(parity_error) + int'(frame_error);
      e.data  = received_data;
      e.stamp = cyc;
      e.kind  = 0;
      if (n > 1)                 e.kind = EV_MULTI;
      else if (received_data_en) e.kind = EV_GOOD;
      else if (parity_error)     e.kind = EV_PERR;
      else if (frame_error)      e.kind = EV_FERR;
      if (e.kind != 0) obs_q.push_back(e);
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // {stop, parity, data, start}; parity is the odd-parity bit, optionally inverted.
   function automatic logic [10:0] build_frame(input logic [7:0] data, input logic flip, input logic stop);
      logic par;
      par = ~(^data) ^ flip;
      return {stop, par, data, 1'b0};
   endfunction

   // Frame-level model of a complete frame.
   task automatic expect_frame(input logic [10:0] f);
      ev_t e;
      e.stamp = 0;
      if (f[10] == 1'b0) begin
         e.kind = EV_FERR; e.data = last_good;
      end else if ((^f[9:1]) == 1'b0) begin
         e.kind = EV_PERR; e.data = last_good;
      end else begin
         e.kind = EV_GOOD; e.data = f[8:1]; last_good = f[8:1];
      end
      exp_q.push_back(e);
   endtask

   task automatic expect_timeout();
      ev_t e;
      e.kind = EV_FERR; e.data = last_good; e.stamp = 0;
      exp_q.push_back(e);
   endtask

   // Data changes mid-high, then the clock falls for one half period.
   task automatic send_bits(input logic [10:0] f, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = f[i];
         idle_cycles(half / 2);
         PS2_CLK = 1'b0;
         last_fe_cyc = cyc;
         idle_cycles(half);
         PS2_CLK = 1'b1;
         idle_cycles(half - half / 2);
      end
      PS2_DAT = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic flip, input logic stop, input int half);
      logic [10:0] f;
      f = build_frame(data, flip, stop);
      expect_frame(f);
      send_bits(f, 11, half);
   endtask

   task automatic check_events(input string tag);
      ev_t e;
      ev_t o;
      idle_cycles(40);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            check_value({tag, "_missing"}, 32'd0, 32'(e.kind));
         end else begin
            o = obs_q.pop_front();
            check_value({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
            check_value({tag, "_data"}, {24'd0, o.data}, {24'd0, e.data});
         end
      end
      check_value({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
      obs_q.delete();
      check_value({tag, "_held"}, {24'd0, received_data}, {24'd0, last_good});
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_data"},  {24'd0, received_data}, 32'd0);
      check_value({tag, "_en"},    {31'd0, received_data_en}, 32'd0);
      check_value({tag, "_perr"},  {31'd0, parity_error}, 32'd0);
      check_value({tag, "_ferr"},  {31'd0, frame_error}, 32'd0);
   endtask

   initial begin
      logic [7:0] codes [7];
      logic [7:0] d;
      codes[0] = SC_BREAK; codes[1] = SC_SPACE; codes[2] = SC_A; codes[3] = SC_S;
      codes[4] = SC_D;     codes[5] = SC_F;     codes[6] = SC_EMPTY;

      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      reset   = 1'b1;
      idle_cycles(5);
      check_reset_outputs("reset");
      reset = 1'b0;
      idle_cycles(20);

      // 1: single good frame at the slow bus rate, with strobe timing.
      send_frame(SC_A, 1'b0, 1'b1, 1000);
      idle_cycles(40);
      check_value("t1_count", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0)
         check_value("t1_latency", 32'(obs_q[0].stamp - last_fe_cyc), 32'(STROBE_LATENCY));
      check_events("t1");

      // 2: back-to-back break prefix and make code.
      send_frame(SC_BREAK, 1'b0, 1'b1, 60);
      send_frame(SC_A, 1'b0, 1'b1, 60);
      check_events("t2");

      // 3: parity forced wrong.
      send_frame(SC_SPACE, 1'b1, 1'b1, 60);
      check_events("t3");

      // 4: bad stop bit with good parity, then a good frame.
      send_frame(SC_S, 1'b0, 1'b0, 60);
      check_events("t4_stop");
      send_frame(SC_D, 1'b0, 1'b1, 60);
      check_events("t4_good");

      // 5: partial frame abandoned by timeout, then a good frame.
      send_bits(build_frame(SC_F, 1'b0, 1'b1), 5, 60);
      expect_timeout();
      idle_cycles(10_200);
      check_events("t5_timeout");
      send_frame(SC_F, 1'b0, 1'b1, 60);
      check_events("t5_good");

      // 6: reset mid-frame, a clock glitch, then a good frame.
      send_bits(build_frame(SC_D, 1'b0, 1'b1), 6, 60);
      reset = 1'b1;
      last_good = 8'h00;
      idle_cycles(5);
      check_reset_outputs("t6_reset");
      reset = 1'b0;
      idle_cycles(20);
      check_events("t6_abort");
      PS2_DAT = 1'b0;
      idle_cycles(10);
      PS2_CLK = 1'b0;
      idle_cycles(3);
      PS2_CLK = 1'b1;
      idle_cycles(30);
      PS2_DAT = 1'b1;
      idle_cycles(20);
      send_frame(SC_A, 1'b0, 1'b1, 60);
      check_events("t6_good");

      // Randomised frames: mixed codes, parity and stop faults, bus rates, gaps.
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 0) d = codes[$urandom_range(0, 6)];
         else                           d = 8'($urandom);
         send_frame(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                    int'($urandom_range(30, 80)));
         idle_cycles(int'($urandom_range(0, 30)));
         check_events($sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
